// File: rtl/cmd_fill_engine.sv
// Bulk write engine for video memory: streams one write per clock for CLEAR/FILL/FILL_RANGE.
// Optional PATTERN opcode (8'h04) is enabled by defining CMD_FILL_PATTERN_EN.
module cmd_fill_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        command,
    input  logic              request,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [ADDR_W:0]   user_len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic [ADDR_W-1:0] cmd_mem_addr,
    output logic [DATA_W-1:0] cmd_mem_data,
    output logic              cmd_mem_wren,
    output logic              active,
    output logic              done,
    output logic              error
);

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_CLEAR      = 8'h01;
    localparam logic [7:0] OP_FILL       = 8'h02;
    localparam logic [7:0] OP_FILL_RANGE = 8'h03;
    localparam logic [7:0] OP_PATTERN    = 8'h04;

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     remaining_reg, remaining_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                wren_reg, wren_next;
    logic                active_reg, active_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;
    logic                pattern_reg, pattern_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            wren_reg      <= 1'b0;
            active_reg    <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            pattern_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            wren_reg      <= wren_next;
            active_reg    <= active_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            pattern_reg   <= pattern_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        wren_next      = wren_reg;
        active_next    = active_reg;
        pattern_next   = pattern_reg;
        done_next      = 1'b0;
        error_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (request) begin
                    case (command)
                        OP_NOP: ;
                        OP_CLEAR: begin
                            state_next     = RUN;
                            remaining_next = FULL_LEN;
                            addr_next      = '0;
                            data_next      = '0;
                            wren_next      = 1'b1;
                            active_next    = 1'b1;
                            pattern_next   = 1'b0;
                        end
                        OP_FILL: begin
                            state_next     = RUN;
                            remaining_next = FULL_LEN;
                            addr_next      = '0;
                            data_next      = fill_value;
                            wren_next      = 1'b1;
                            active_next    = 1'b1;
                            pattern_next   = 1'b0;
                        end
                        OP_FILL_RANGE: begin
                            // Zero length still passes through RUN so done lands one edge later.
                            state_next     = RUN;
                            remaining_next = user_len;
                            addr_next      = user_addr;
                            pattern_next   = 1'b0;
                            if (user_len != '0) begin
                                data_next   = fill_value;
                                wren_next   = 1'b1;
                                active_next = 1'b1;
                            end
                        end
`ifdef CMD_FILL_PATTERN_EN
                        OP_PATTERN: begin
                            state_next     = RUN;
                            remaining_next = FULL_LEN;
                            addr_next      = '0;
                            data_next      = fill_value;
                            wren_next      = 1'b1;
                            active_next    = 1'b1;
                            pattern_next   = 1'b1;
                        end
`endif
                        default: error_next = 1'b1;
                    endcase
                end
            end
            RUN: begin
                if (abort) begin
                    state_next  = IDLE;
                    wren_next   = 1'b0;
                    active_next = 1'b0;
                    addr_next   = '0;
                    data_next   = '0;
                end else if (remaining_reg > 1) begin
                    remaining_next = remaining_reg - 1'b1;
                    addr_next      = addr_reg + 1'b1;
                    if (pattern_reg) begin
                        data_next = data_reg + 1'b1;
                    end
                end else begin
                    state_next  = DONE;
                    wren_next   = 1'b0;
                    active_next = 1'b0;
                    done_next   = 1'b1;
                    addr_next   = '0;
                    data_next   = '0;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_mem_addr = addr_reg;
    assign cmd_mem_data = data_reg;
    assign cmd_mem_wren = wren_reg;
    assign active       = active_reg;
    assign done         = done_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_cmd_fill_engine.sv
// Scoreboard bench for cmd_fill_engine (ADDR_W=4): expected writes/done/error events
// are queued with their cycle stamps and matched by an independent negedge monitor.
module tb_cmd_fill_engine;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    command = '0;
    logic          request = 1'b0;
    logic [AW-1:0] user_addr = '0;
    logic [AW:0]   user_len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] cmd_mem_addr;
    logic [DW-1:0] cmd_mem_data;
    logic          cmd_mem_wren;
    logic          active;
    logic          done;
    logic          error;

    cmd_fill_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .command(command), .request(request),
        .user_addr(user_addr), .user_len(user_len), .fill_value(fill_value), .abort(abort),
        .cmd_mem_addr(cmd_mem_addr), .cmd_mem_data(cmd_mem_data), .cmd_mem_wren(cmd_mem_wren),
        .active(active), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    localparam int K_WRITE = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERROR = 2;

    typedef struct {
        int            kind;
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({name, " kind"}, kind, e.kind);
            chk({name, " cycle"}, cyc, e.cyc);
            if (kind == K_WRITE) begin
                chk({name, " addr"}, {28'd0, cmd_mem_addr}, {28'd0, e.addr});
                chk({name, " data"}, {24'd0, cmd_mem_data}, {24'd0, e.data});
            end
            $display("cyc %0d %s addr=%0h data=%0h", cyc, name, cmd_mem_addr, cmd_mem_data);
        end
    endtask

    // Monitor: runs independently of stimulus.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("active_eq_wren", {31'd0, active}, {31'd0, cmd_mem_wren});
            if (!cmd_mem_wren) chk("idle_data_zero", {24'd0, cmd_mem_data}, 32'd0);
            if (error) take(K_ERROR, "error");
            if (done) take(K_DONE, "done");
            if (cmd_mem_wren) take(K_WRITE, "write");
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int kind, input int c, input int a, input int d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a[AW-1:0];
        e.data = d[DW-1:0];
        exp_q.push_back(e);
    endtask

    // Returns the cycle stamp of the accepting edge.
    task automatic issue(input logic [7:0] cmd, input int a, input int len, input int val,
                         output int n);
        command    = cmd;
        user_addr  = a[AW-1:0];
        user_len   = len[AW:0];
        fill_value = val[DW-1:0];
        request    = 1'b1;
        tick();
        request    = 1'b0;
        n          = cyc;
    endtask

    task automatic push_run(input int n, input int a, input int len, input int val,
                            input int step, input int nwr, input bit with_done);
        for (int k = 0; k < nwr; k++) push(K_WRITE, n + k, a + k, val + k * step);
        if (with_done) push(K_DONE, n + len, 0, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL %s: %0d expected events never seen", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        int n;
        #12;
        chk("reset wren", {31'd0, cmd_mem_wren}, 32'd0);
        chk("reset active", {31'd0, active}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset error", {31'd0, error}, 32'd0);
        chk("reset addr", {28'd0, cmd_mem_addr}, 32'd0);
        reset_n = 1'b1;
        tick();

        // CLEAR: 16 writes of 0, with a stray request mid-run that must be ignored.
        issue(8'h01, 0, 0, 8'h99, n);
        push_run(n, 0, 16, 0, 0, 16, 1'b1);
        repeat (3) tick();
        command = 8'h7F; request = 1'b1;
        tick();
        request = 1'b0;
        drain("clear");

        // FILL_RANGE wrapping past the top address; inputs changed mid-run.
        issue(8'h03, 14, 4, 8'hA5, n);
        push_run(n, 14, 4, 8'hA5, 0, 4, 1'b1);
        fill_value = 8'h11; user_addr = 4'd2; user_len = 5'd9;
        drain("range_wrap");

        // FILL_RANGE with zero length: done one edge later, no writes.
        issue(8'h03, 5, 0, 8'h77, n);
        push(K_DONE, n + 1, 0, 0);
        drain("range_zero");

        // NOP and abort-in-IDLE: nothing observable.
        issue(8'h00, 0, 0, 0, n);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain("nop");

        // Invalid opcode, then a normal CLEAR.
        issue(8'h7F, 0, 0, 0, n);
        push(K_ERROR, n, 0, 0);
        drain("invalid");
        issue(8'h01, 0, 0, 8'h42, n);
        push_run(n, 0, 16, 0, 0, 16, 1'b1);
        drain("clear_after_err");

        // FILL aborted during the 6th write.
        issue(8'h02, 0, 0, 8'h3C, n);
        push_run(n, 0, 16, 8'h3C, 0, 6, 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain("abort");

        // Abort coinciding with the last write of a range: no done.
        issue(8'h03, 9, 3, 8'h5A, n);
        push_run(n, 9, 3, 8'h5A, 0, 3, 1'b0);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain("abort_last");

        // Asynchronous reset mid-run clears outputs immediately.
        issue(8'h02, 0, 0, 8'h55, n);
        push_run(n, 0, 16, 8'h55, 0, 3, 1'b0);
        repeat (2) tick();
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async wren", {31'd0, cmd_mem_wren}, 32'd0);
        chk("async active", {31'd0, active}, 32'd0);
        chk("async data", {24'd0, cmd_mem_data}, 32'd0);
        chk("async addr", {28'd0, cmd_mem_addr}, 32'd0);
        tick();
        reset_n = 1'b1;
        drain("reset_mid");
        issue(8'h03, 3, 2, 8'hC3, n);
        push_run(n, 3, 2, 8'hC3, 0, 2, 1'b1);
        drain("after_reset");

        // PATTERN: incrementing data when enabled, otherwise rejected.
        issue(8'h04, 0, 0, 8'hFE, n);
`ifdef CMD_FILL_PATTERN_EN
        push_run(n, 0, 16, 8'hFE, 1, 16, 1'b1);
`else
        push(K_ERROR, n, 0, 0);
`endif
        drain("pattern");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
